aes_256_key_expand: RTL

- Iterative AES-256 key schedule (FIPS-197) directly upstream of the AES_256 round datapath.
- Latches a 256-bit cipher key on a start pulse and generates all 15 round keys, one 128-bit round key per clock.
- Stores the round keys in an internal register file and serves them through an indexed, registered read port.
- The core reads ascending indices for encryption and descending indices for decryption, so expansion runs once per key change.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_sbox.sv | 17 +
 rtl/aes_256_key_expand.sv | 133 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions used by the AES-256 key schedule and round datapath:
// round/key constants, key-schedule state encoding, the RCON table and the
// forward S-box lookup function.
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR          = 14;        // rounds; round keys 0..NR stored
    localparam int NK          = 8;         // 32-bit words in an AES-256 key
    localparam int KW          = NK * 32;   // cipher key width
    localparam int ROUND_KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_e;

    // Indexed by i/2 for even round-key index i; entry 0 is never selected.
    localparam logic [7:0] RCON [0:7] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational 8-bit AES forward S-box.
// Ports:
//   in_byte  in  8  byte to substitute
//   out_byte out 8  SubBytes(in_byte)
// ---------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_lookup(in_byte);

endmodule

// File: rtl/aes_256_key_expand.sv
// ---------------------------------------------------------------------------
// aes_256_key_expand
// Iterative AES-256 key schedule. A start pulse latches the cipher key, then
// one 128-bit round key is generated per clock into a 15-entry register file,
// which is read back through a registered, indexed port.
// Ports:
//   Clk        in   1    rising-edge clock
//   Rst        in   1    asynchronous active-high reset
//   En         in   1    start pulse, honoured in IDLE or READY only
//   cipher_key in   256  key, [255:224] = w0 ... [31:0] = w7
//   rk_addr    in   4    round-key index 0..14 (larger reads return 0)
//   round_key  out  128  rk[rk_addr], one cycle after the address
//   busy       out  1    high while expanding
//   done       out  1    high while all round keys are valid
// ---------------------------------------------------------------------------
module aes_256_key_expand
    import aes_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   En,
    input  logic [KW-1:0]          cipher_key,
    input  logic [3:0]             rk_addr,
    output logic [ROUND_KEY_W-1:0] round_key,
    output logic                   busy,
    output logic                   done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e              state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ROUND_KEY_W-1:0] rk_q [0:NR];
    logic [ROUND_KEY_W-1:0] rk_d [0:NR];
    logic [ROUND_KEY_W-1:0] round_key_q, round_key_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [ROUND_KEY_W-1:0] prev_rk, prev2_rk;
    logic [31:0]            sub_in, sub_out, t_word;
    logic [31:0]            n0, n1, n2, n3;

    // The two most recent round keys feed the next one; guarded so an idle
    // counter never indexes outside the register file.
    always_comb begin
        prev_rk  = '0;
        prev2_rk = '0;
        if (cnt_q >= 4'd2 && cnt_q <= LAST_IDX) begin
            prev_rk  = rk_q[cnt_q - 4'd1];
            prev2_rk = rk_q[cnt_q - 4'd2];
        end
    end

    // Even index: RotWord then SubWord (+RCON); odd index: SubWord only.
    assign sub_in = cnt_q[0] ? prev_rk[31:0] : {prev_rk[23:0], prev_rk[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*g +: 8]),
            .out_byte (sub_out[8*g +: 8])
        );
    end

    assign t_word = sub_out ^ (cnt_q[0] ? 32'h0 : {RCON[cnt_q[3:1]], 24'h0});
    assign n0     = prev2_rk[127:96] ^ t_word;
    assign n1     = prev2_rk[95:64]  ^ n0;
    assign n2     = prev2_rk[63:32]  ^ n1;
    assign n3     = prev2_rk[31:0]   ^ n2;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        rk_d    = rk_q;

        unique case (state_q)
            IDLE, READY: begin
                if (En) begin
                    rk_d[0] = cipher_key[255:128];
                    rk_d[1] = cipher_key[127:0];
                    cnt_d   = 4'd2;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                rk_d[cnt_q] = {n0, n1, n2, n3};
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase

        round_key_d = (rk_addr <= LAST_IDX) ? rk_q[rk_addr] : '0;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            round_key_q <= '0;
            // NOTE: the register file is cleared on reset so reads before the
            // first expansion return zeros; it is small enough to be flops.
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            round_key_q <= round_key_d;
            rk_q        <= rk_d;
        end
    end

    assign round_key = round_key_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
